// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
//
// Downstream stage of the FIR filter. Every block of D = 2^dec_log2 enabled
// input samples is summed and divided by D (arithmetic shift, rounding toward
// minus infinity). Each block average is pushed into a small FIFO that drains
// to the next consumer through a valid/ready handshake. If a result arrives
// while the FIFO is full and nothing is leaving in the same cycle, the result
// is dropped and a sticky overflow flag is raised.
//
// Parameters:
//   datawidth  - width of input samples and output results (signed)
//   dec_log2   - log2 of the decimation factor D (>= 1)
//   depth_log2 - log2 of the FIFO depth F (>= 1)
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous active-high reset
//   y_in       - signed sample from the FIR filter
//   in_en      - y_in is valid and counts toward the current block
//   m_data     - signed averaged result at the FIFO head, 0 when empty
//   m_valid    - FIFO holds at least one result
//   m_ready    - consumer takes m_data this cycle
//   fifo_count - number of results currently stored (0..F)
//   overflow   - sticky, a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module fir_decimator #(
  parameter int datawidth  = 8,
  parameter int dec_log2   = 2,
  parameter int depth_log2 = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [datawidth-1:0] y_in,
  input  logic                        in_en,
  output logic signed [datawidth-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [depth_log2:0]         fifo_count,
  output logic                        overflow
);

  localparam int acc_width = datawidth + dec_log2;
  localparam int fifo_depth = 1 << depth_log2;
  localparam logic [depth_log2:0] count_full = (depth_log2 + 1)'(fifo_depth);

  // Block accumulation state
  logic [dec_log2-1:0]         cnt;
  logic signed [acc_width-1:0] acc;

  // FIFO state
  logic [datawidth-1:0]  mem [fifo_depth];
  logic [depth_log2-1:0] rd_ptr;
  logic [depth_log2-1:0] wr_ptr;
  logic [depth_log2:0]   count;
  logic                  overflow_q;

  // Datapath and control intermediates
  logic signed [acc_width-1:0] y_ext;
  logic signed [acc_width-1:0] sum;
  logic signed [acc_width-1:0] shifted;
  logic [datawidth-1:0]        result;
  logic                        dump;
  logic                        full;
  logic                        pop;
  logic                        push;
  logic                        drop;
  logic [depth_log2:0]         count_next;

  // The accumulator is wide enough for a whole block of extreme samples, so
  // the sum never wraps and the shifted average always fits in datawidth
  // bits. Taking the low bits is therefore exact, no saturation needed.
  always_comb begin
    y_ext   = {{dec_log2{y_in[datawidth-1]}}, y_in};
    sum     = acc + y_ext;
    shifted = sum >>> dec_log2;
    result  = shifted[datawidth-1:0];
  end

  // A dump happens on the D-th enabled sample of a block. When the FIFO is
  // full, a pop in the same cycle frees the head slot, and because the write
  // pointer equals the read pointer in that case the new result lands exactly
  // in the slot being read out, which is safe since the read is combinational
  // and completes before the edge.
  always_comb begin
    dump = in_en && (cnt == '1);
    full = (count == count_full);
    pop  = m_valid && m_ready;
    push = dump && (!full || pop);
    drop = dump && full && !pop;
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Sample counter and accumulator; a reset abandons any partial block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (in_en) begin
      if (dump) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= sum;
      end
    end
  end

  // FIFO storage is not reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= result;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers are
  // exactly depth_log2 bits wide so they wrap modulo F on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head of FIFO is presented combinationally and forced to zero when empty.
  always_comb begin
    m_valid    = (count != '0);
    m_data     = m_valid ? mem[rd_ptr] : '0;
    fifo_count = count;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_fir_decimator.sv
// -----------------------------------------------------------------------------
// tb_fir_decimator
//
// Directed testbench for fir_decimator with the default parameters
// (datawidth 8, D = 4, F = 4). Inputs are driven 1 ns after each rising edge
// and outputs are checked at that same point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_fir_decimator;

  logic       clk;
  logic       rst;
  logic [7:0] y_in;
  logic       in_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [2:0] fifo_count;
  logic       overflow;

  int vectors;
  int miscompares;

  fir_decimator #(
    .datawidth (8),
    .dec_log2  (2),
    .depth_log2(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .y_in      (y_in),
    .in_en     (in_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of inputs and let it take effect at the next edge.
  task automatic applyStimulus(input logic en, input logic [7:0] y, input logic ready);
    in_en   = en;
    y_in    = y;
    m_ready = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Four enabled samples back to back, same ready level throughout.
  task automatic sendBlock(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d,
                           input logic ready);
    applyStimulus(1'b1, a, ready);
    applyStimulus(1'b1, b, ready);
    applyStimulus(1'b1, c, ready);
    applyStimulus(1'b1, d, ready);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_en       = 1'b0;
    y_in        = 8'h00;
    m_ready     = 1'b0;

    // Reset state
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("rst_valid", 16'(m_valid), 16'd0);
    checkOutput("rst_count", 16'(fifo_count), 16'd0);
    checkOutput("rst_data", 16'(m_data), 16'd0);
    checkOutput("rst_ovf", 16'(overflow), 16'd0);
    rst = 1'b0;

    // Basic block 10,20,30,40 -> 25, valid for exactly one cycle
    applyStimulus(1'b1, 8'd10, 1'b1);
    applyStimulus(1'b1, 8'd20, 1'b1);
    applyStimulus(1'b1, 8'd30, 1'b1);
    checkOutput("basic_not_early", 16'(m_valid), 16'd0);
    applyStimulus(1'b1, 8'd40, 1'b1);
    checkOutput("basic_valid", 16'(m_valid), 16'd1);
    checkOutput("basic_data", 16'(m_data), 16'd25);
    checkOutput("basic_count", 16'(fifo_count), 16'd1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("basic_one_cycle", 16'(m_valid), 16'd0);
    checkOutput("basic_count_0", 16'(fifo_count), 16'd0);

    // Rounding toward minus infinity and extreme values
    sendBlock(8'hFF, 8'hFE, 8'hFE, 8'hFE, 1'b1);
    checkOutput("round_neg", 16'(m_data), 16'h00FE);
    applyStimulus(1'b0, 8'd0, 1'b1);
    sendBlock(8'd127, 8'd127, 8'd127, 8'd127, 1'b1);
    checkOutput("max_pos", 16'(m_data), 16'd127);
    applyStimulus(1'b0, 8'd0, 1'b1);
    sendBlock(8'h80, 8'h80, 8'h80, 8'h80, 1'b1);
    checkOutput("max_neg", 16'(m_data), 16'h0080);
    applyStimulus(1'b0, 8'd0, 1'b1);
    sendBlock(8'd1, 8'd1, 8'd1, 8'd0, 1'b1);
    checkOutput("round_pos_valid", 16'(m_valid), 16'd1);
    checkOutput("round_pos", 16'(m_data), 16'd0);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("round_drained", 16'(fifo_count), 16'd0);

    // Enable gaps with garbage on y_in
    applyStimulus(1'b1, 8'd4, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h55, 1'b1);
    applyStimulus(1'b1, 8'd8, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h80, 1'b1);
    applyStimulus(1'b1, 8'd12, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h7F, 1'b1);
    checkOutput("gap_no_result", 16'(m_valid), 16'd0);
    applyStimulus(1'b1, 8'd16, 1'b1);
    checkOutput("gap_data", 16'(m_data), 16'd10);
    applyStimulus(1'b0, 8'hAA, 1'b1);
    checkOutput("gap_single", 16'(fifo_count), 16'd0);

    // Back-pressure: five results into a four-entry FIFO
    for (int k = 1; k <= 5; k++) begin
      sendBlock(8'(k), 8'(k), 8'(k), 8'(k), 1'b0);
    end
    checkOutput("bp_count", 16'(fifo_count), 16'd4);
    checkOutput("bp_ovf", 16'(overflow), 16'd1);
    checkOutput("bp_head", 16'(m_data), 16'd1);
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("bp_hold", 16'(m_data), 16'd1);
    checkOutput("bp_hold_valid", 16'(m_valid), 16'd1);
    for (int k = 2; k <= 4; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("bp_drain_valid", 16'(m_valid), 16'd1);
      checkOutput("bp_drain_data", 16'(m_data), 16'(k));
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("bp_empty", 16'(m_valid), 16'd0);
    checkOutput("bp_ovf_sticky", 16'(overflow), 16'd1);

    // Reset, then full FIFO with a dump coinciding with a pop
    rst = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0);
    rst = 1'b0;
    checkOutput("ovf_cleared", 16'(overflow), 16'd0);
    for (int k = 5; k <= 8; k++) begin
      sendBlock(8'(k), 8'(k), 8'(k), 8'(k), 1'b0);
    end
    checkOutput("pp_full", 16'(fifo_count), 16'd4);
    applyStimulus(1'b1, 8'd9, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b1);
    checkOutput("pp_count", 16'(fifo_count), 16'd4);
    checkOutput("pp_ovf", 16'(overflow), 16'd0);
    checkOutput("pp_head", 16'(m_data), 16'd6);
    for (int k = 7; k <= 9; k++) begin
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("pp_drain", 16'(m_data), 16'(k));
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("pp_empty", 16'(m_valid), 16'd0);

    // Reset mid-operation: two results queued and a partial block
    sendBlock(8'd3, 8'd3, 8'd3, 8'd3, 1'b0);
    sendBlock(8'd5, 8'd5, 8'd5, 8'd5, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b0);
    applyStimulus(1'b1, 8'd7, 1'b0);
    checkOutput("mid_queued", 16'(fifo_count), 16'd2);
    rst = 1'b1;
    applyStimulus(1'b1, 8'd100, 1'b1);
    rst = 1'b0;
    checkOutput("mid_valid", 16'(m_valid), 16'd0);
    checkOutput("mid_ovf", 16'(overflow), 16'd0);
    checkOutput("mid_count", 16'(fifo_count), 16'd0);
    applyStimulus(1'b1, 8'd8, 1'b1);
    applyStimulus(1'b1, 8'd8, 1'b1);
    applyStimulus(1'b1, 8'd8, 1'b1);
    checkOutput("mid_no_partial", 16'(m_valid), 16'd0);
    applyStimulus(1'b1, 8'd8, 1'b1);
    checkOutput("mid_data", 16'(m_data), 16'd8);
    checkOutput("mid_count1", 16'(fifo_count), 16'd1);
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("mid_only", 16'(m_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the FIR filter. Takes the filter's signed output samples, averages each block of 2^dec_log2 enabled samples (accumulate-and-dump decimation) and queues the results in a small FIFO. The FIFO drains through a valid/ready handshake to the next consumer. A sticky overflow flag reports results dropped under sustained back-pressure.

## Interface
Parameters:
- datawidth, 8, bit-width of input samples and output results (signed two's complement)
- dec_log2, 2, log2 of the decimation factor D (default D = 4); must be ≥ 1
- depth_log2, 2, log2 of the FIFO depth F (default F = 4); must be ≥ 1

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- y_in  input  datawidth  signed sample from the FIR filter output
- in_en  input  1  y_in is valid this cycle and counts toward the current block
- m_data  output  datawidth  signed averaged result at the FIFO head; 0 when m_valid is low
- m_valid  output  1  FIFO not empty
- m_ready  input  1  consumer accepts m_data this cycle
- fifo_count  output  depth_log2+1  number of results currently stored (0..F)
- overflow  output  1  sticky; a result was dropped because the FIFO was full

## Operation
- State:
  - sample counter cnt, 0..D-1
  - signed accumulator acc, datawidth+dec_log2 bits
  - FIFO of F entries with read pointer, write pointer and count
  - overflow flag
- in_en low: cnt and acc hold. Cycles without in_en never count toward a block.
- in_en high with cnt < D-1: acc <= acc + sign-extended y_in; cnt <= cnt+1.
- in_en high with cnt == D-1 (dump):
  - result = (acc + y_in) >>> dec_log2, an arithmetic shift that rounds toward −∞.
  - acc <= 0 and cnt <= 0.
  - The result is pushed to the FIFO.
- Width rule: the accumulator cannot overflow. The result is always in [−2^(datawidth−1), 2^(datawidth−1)−1], so it is taken as the low datawidth bits with no saturation.
- Pop: occurs on every cycle where m_valid && m_ready. The read pointer advances and count decrements.
- Push while not full: the entry is written at the write pointer and count increments.
- Push while full:
  - With a pop in the same cycle: the push is accepted, the pop frees the slot, and count is unchanged.
  - Without a pop: the result is discarded, the FIFO is unchanged, and overflow <= 1.
- Pop while empty: not possible, because m_valid is low.
- Push and pop in the same cycle while not full: both happen and count is unchanged.
- Pointers wrap modulo F.
- Ordering is strict FIFO.
- While m_valid && !m_ready, m_data must be held stable.
- overflow clears only on rst.

## Timing
- Reset: on a clock edge with rst high:
  - cnt = 0 and acc = 0.
  - Pointers and count = 0, so fifo_count = 0 and m_valid = 0.
  - m_data = 0 and overflow = 0.
  - Any partial block is discarded. FIFO memory contents need not be cleared.
- rst has priority over in_en and m_ready in the same cycle.
- Latency: when the D-th sample is presented with in_en in cycle k, the result is written at the end of cycle k. m_valid and m_data show it in cycle k+1 if the FIFO was empty.
- Throughput: one result per D enabled samples. The FIFO accepts one push and one pop per cycle.
- fifo_count and overflow are registered and update at the same edge as the push or pop that changes them.
- m_data is the combinational read of the head entry, gated by m_valid.

## Test plan
- Reset, then in_en=1 with y_in = 10,20,30,40 and m_ready=1 → m_data=25 with m_valid high for exactly one cycle, starting the cycle after the sample 40; fifo_count returns to 0.
- Rounding and extremes:
  - Block −1,−2,−2,−2 (sum −7) → −2.
  - Block 4×127 → 127.
  - Block 4×−128 → −128.
  - Block 1,1,1,0 → 0.
- Enable gaps: samples 4,8,12,16 with in_en low for 3 cycles between each and garbage on y_in during the gaps → a single result of 10.
- Back-pressure and overflow:
  - With m_ready=0, send 20 samples whose block averages are 1,2,3,4,5.
  - Required: fifo_count=4 and overflow=1; the 5th result is dropped.
  - Then raise m_ready=1 → results 1,2,3,4 drain on 4 consecutive cycles, m_data holds while stalled, and overflow stays 1.
- Full plus simultaneous push/pop: fill the FIFO (count=4) and assert m_ready in the same cycle as a dump of value 9 → no drop, overflow stays 0, fifo_count stays 4, and 9 drains last.
- Reset mid-operation: 2 samples into a block with 2 results queued, pulse rst for one cycle, then send 4×8 → m_valid=0 and overflow=0 after reset, and the only output is 8.
